// File: rtl/bus_arbiter.sv
// ============================================================================
// Module  : bus_arbiter
// Brief   : Two-master Wishbone classic round-robin arbiter with fault/timeout err.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    input  logic        s_fault_i,
    output logic [1:0]  grant_o
);

    // State encoding doubles as the one-hot grant vector.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_OWN0 = 2'b01;
    localparam logic [1:0] ST_OWN1 = 2'b10;

    localparam logic [CNT_W-1:0] C_TC = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic             last_served_q, last_served_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             w_tc;

    assign grant_o = state_q;
    assign w_tc    = (wdog_q == C_TC);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            last_served_q <= 1'b1;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            wdog_q        <= wdog_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_served_q ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc_i) begin
                    state_d = ST_OWN0;
                end else if (m1_cyc_i) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!m0_cyc_i) begin
                    state_d       = ST_IDLE;
                    last_served_d = 1'b0;
                end
            end
            ST_OWN1: begin
                if (!m1_cyc_i) begin
                    state_d       = ST_IDLE;
                    last_served_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Watchdog counts unanswered strobe cycles; terminal count wraps to zero.
    always_comb begin
        wdog_d = '0;
        if (s_stb_o && !s_ack_i && !w_tc && (state_d == state_q)) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        case (state_q)
            ST_OWN0: begin
                s_cyc_o  = m0_cyc_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_dat_o = s_dat_i;
            end
            ST_OWN1: begin
                s_cyc_o  = m1_cyc_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_dat_o = s_dat_i;
            end
            default: ;
        endcase
    end

    // Kept apart from the address mux: s_fault_i is combinational from s_adr_o.
    always_comb begin
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            ST_OWN0: begin
                s_stb_o  = m0_cyc_i & m0_stb_i & ~s_fault_i;
                m0_ack_o = m0_cyc_i & m0_stb_i & s_ack_i & ~s_fault_i;
                m0_err_o = m0_cyc_i & m0_stb_i & (s_fault_i | (~s_ack_i & w_tc));
            end
            ST_OWN1: begin
                s_stb_o  = m1_cyc_i & m1_stb_i & ~s_fault_i;
                m1_ack_o = m1_cyc_i & m1_stb_i & s_ack_i & ~s_fault_i;
                m1_err_o = m1_cyc_i & m1_stb_i & (s_fault_i | (~s_ack_i & w_tc));
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module  : tb_bus_arbiter
// Brief   : Directed scoreboard bench for bus_arbiter (TIMEOUT=8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    logic        clk, rst_n;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdat, m1_rdat;
    logic        s_cyc, s_stb, s_we, s_ack, s_fault;
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic [3:0]  s_sel;
    logic [1:0]  grant;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;

    typedef struct packed {
        int          cyc;
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] d0;
        logic [31:0] d1;
    } exp_t;

    exp_t q[$];
    exp_t e;

    bus_arbiter #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m0_dat_o(m0_rdat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .m1_dat_o(m1_rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
        .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_ack_i(s_ack), .s_dat_i(s_rdat),
        .s_fault_i(s_fault), .grant_o(grant)
    );

    // Decoder model: region 0x5xxx_xxxx is unmapped.
    assign s_fault = s_cyc & (s_adr[31:28] == 4'h5);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input int c, input logic [1:0] a, input logic [1:0] er,
                              input logic [31:0] d0, input logic [31:0] d1);
        exp_t x;
        x.cyc = c; x.ack = a; x.err = er; x.d0 = d0; x.d1 = d1;
        q.push_back(x);
    endtask

    // Monitor: every ack/err presented by the DUT must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && (m0_ack || m0_err || m1_ack || m1_err)) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: cyc=%0d ack=%b err=%b want none",
                         cyc_cnt, {m1_ack, m0_ack}, {m1_err, m0_err});
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc_cnt || {m1_ack, m0_ack} !== e.ack || {m1_err, m0_err} !== e.err ||
                    m0_rdat !== e.d0 || m1_rdat !== e.d1) begin
                    bad++;
                    $display("FAIL rsp: got cyc=%0d ack=%b err=%b d0=%h d1=%h want cyc=%0d ack=%b err=%b d0=%h d1=%h",
                             cyc_cnt, {m1_ack, m0_ack}, {m1_err, m0_err}, m0_rdat, m1_rdat,
                             e.cyc, e.ack, e.err, e.d0, e.d1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no end want end");
        $fatal(1);
    end

    initial begin
        int b;
        rst_n = 1'b0;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_dat = 32'h0BAD_0000; m0_sel = 4'hF;
        m1_cyc = 0; m1_stb = 0; m1_we = 1; m1_adr = 0; m1_dat = 32'h0BAD_1111; m1_sel = 4'h3;
        s_ack = 1'b1; s_rdat = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_s_cyc", 32'(s_cyc), 0);
        chk("rst_s_stb", 32'(s_stb), 0);
        chk("rst_m0_ack", 32'(m0_ack), 0);
        chk("rst_m0_dat", m0_rdat, 0);
        chk("rst_m1_dat", m1_rdat, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; s_ack = 1'b0;

        // Contention from reset: m0 first, one dead cycle, then m1, then back to m0.
        tick(); m0_cyc = 1; m1_cyc = 1; m0_stb = 1; m1_stb = 1;
        m0_adr = 32'h0000_1000; m1_adr = 32'h0000_2000;
        #2 chk("tie_idle_grant", 32'(grant), 0);
        chk("tie_idle_stb", 32'(s_stb), 0);
        tick(); s_ack = 1; s_rdat = 32'h1111_1111;
        expect_rsp(cyc_cnt, 2'b01, 2'b00, 32'h1111_1111, 0);
        #2 chk("tie_grant_m0", 32'(grant), 1);
        chk("tie_adr_m0", s_adr, 32'h0000_1000);
        tick(); s_ack = 0; m0_cyc = 0; m0_stb = 0;
        #2 chk("release_edge_grant", 32'(grant), 1);
        tick(); #2 chk("dead_cycle_grant", 32'(grant), 0);
        chk("dead_cycle_stb", 32'(s_stb), 0);
        tick(); s_ack = 1; s_rdat = 32'h2222_2222;
        expect_rsp(cyc_cnt, 2'b10, 2'b00, 0, 32'h2222_2222);
        #2 chk("m1_grant", 32'(grant), 2);
        chk("m1_adr", s_adr, 32'h0000_2000);
        chk("m1_we", 32'(s_we), 1);
        tick(); s_ack = 0; m1_stb = 0; m0_cyc = 1;
        #2 chk("m1_keeps_grant", 32'(grant), 2);
        tick(); m1_cyc = 0;
        #2 chk("m1_release_edge", 32'(grant), 2);
        tick(); m1_cyc = 1;
        #2 chk("rr_idle", 32'(grant), 0);
        tick(); #2 chk("rr_m0_wins", 32'(grant), 1);
        m0_cyc = 0; m1_cyc = 0;
        tick(); #2 chk("rr_idle_after", 32'(grant), 0);

        // Single master read with ack two cycles after the first strobe.
        tick(); m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0010; s_rdat = 32'hDEAD_BEEF;
        #2 chk("rd_idle_grant", 32'(grant), 0);
        tick(); #2 chk("rd_grant", 32'(grant), 1);
        chk("rd_stb", 32'(s_stb), 1);
        chk("rd_adr", s_adr, 32'h0000_0010);
        tick(); #2 chk("rd_no_ack_yet", 32'(m0_ack), 0);
        tick(); s_ack = 1;
        expect_rsp(cyc_cnt, 2'b01, 2'b00, 32'hDEAD_BEEF, 0);
        #2 chk("rd_data", m0_rdat, 32'hDEAD_BEEF);
        tick(); s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick(); #2 chk("rd_done_grant", 32'(grant), 0);

        // Decoder fault on m1: err every cycle, slave not strobed, watchdog idle.
        tick(); m1_cyc = 1; m1_stb = 1; m1_adr = 32'h5000_0000; s_rdat = 32'hCAFE_0001;
        tick(); expect_rsp(cyc_cnt, 2'b00, 2'b10, 0, 32'hCAFE_0001);
        #2 chk("fault_stb", 32'(s_stb), 0);
        chk("fault_err", 32'(m1_err), 1);
        chk("fault_ack", 32'(m1_ack), 0);
        for (int i = 1; i < 10; i++) begin
            tick(); expect_rsp(cyc_cnt, 2'b00, 2'b10, 0, 32'hCAFE_0001);
        end
        tick(); m1_adr = 32'h0000_0100;
        expect_rsp(cyc_cnt + 7, 2'b00, 2'b10, 0, 32'hCAFE_0001);
        repeat (8) tick();
        m1_cyc = 0; m1_stb = 0;
        tick();

        // Watchdog on m0: err at strobe cycles 8 and 16, ack wins at 24.
        tick(); m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0200; s_rdat = 32'hA5A5_0000;
        tick(); b = cyc_cnt;
        expect_rsp(b + 7,  2'b00, 2'b01, 32'hA5A5_0000, 0);
        expect_rsp(b + 15, 2'b00, 2'b01, 32'hA5A5_0000, 0);
        expect_rsp(b + 23, 2'b01, 2'b00, 32'hA5A5_0000, 0);
        repeat (23) tick();
        s_ack = 1;
        #2 chk("tc_ack_no_err", 32'(m0_err), 0);
        tick(); s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick();

        // Bus lock: m0 keeps cyc over three transfers while m1 waits.
        tick(); m0_cyc = 1;
        tick(); m1_cyc = 1; m1_stb = 1; m1_adr = 32'h9999_0000;
        for (int i = 0; i < 3; i++) begin
            tick(); m0_adr = 32'h0000_0300 + 32'(4 * i); m0_stb = 1; s_ack = 1;
            s_rdat = 32'h7000_0000 + 32'(i);
            expect_rsp(cyc_cnt, 2'b01, 2'b00, 32'h7000_0000 + 32'(i), 0);
            #2 chk("lock_adr_xfer", s_adr, 32'h0000_0300 + 32'(4 * i));
            tick(); s_ack = 0; m0_stb = 0; m0_adr = 32'h0000_0400 + 32'(i);
            #2 chk("lock_adr_gap", s_adr, 32'h0000_0400 + 32'(i));
            chk("lock_grant", 32'(grant), 1);
        end
        tick(); m0_cyc = 0;
        tick(); #2 chk("lock_dead", 32'(grant), 0);
        tick(); #2 chk("lock_m1_grant", 32'(grant), 2);
        chk("lock_m1_adr", s_adr, 32'h9999_0000);
        m1_cyc = 0; m1_stb = 0;
        tick();

        // Short m0 ownership so last_served is 0 before the reset test.
        tick(); m0_cyc = 1;
        tick(); m0_cyc = 0;
        tick();

        // Asynchronous reset mid-transfer, then m0 wins a tie.
        tick(); m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0600;
        tick(); #2 chk("ar_stb_before", 32'(s_stb), 1);
        #2 rst_n = 1'b0; m1_cyc = 1;
        #1 chk("ar_s_cyc", 32'(s_cyc), 0);
        chk("ar_s_stb", 32'(s_stb), 0);
        chk("ar_grant", 32'(grant), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick(); #2 chk("ar_tie_m0", 32'(grant), 1);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0;
        repeat (3) tick();

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL rsp_missing: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Two-master Wishbone classic arbiter in front of the shared system bus and address decoder. Master 0 is CPU instruction fetch; master 1 is CPU data/DMA. It grants the bus round-robin and holds the grant for a whole cyc. It forwards the owner's request to the decoder and slaves, and returns ack and read data to the owner. It terminates a cycle with err on a decoder fault or on a slave that never acks (watchdog).

Parameters:
TIMEOUT, 1024, cycles of strobe-without-ack before err is forced (range 4..65535)
CNT_W, 16, watchdog counter width; must hold TIMEOUT-1

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset, asynchronous, active-low
m0_cyc_i / m1_cyc_i  in  1  master bus-cycle request / hold
m0_stb_i / m1_stb_i  in  1  master strobe
m0_we_i / m1_we_i  in  1  write enable
m0_adr_i / m1_adr_i  in  32  byte address
m0_dat_i / m1_dat_i  in  32  write data
m0_sel_i / m1_sel_i  in  4  byte selects
m0_ack_o / m1_ack_o  out  1  transfer acknowledge
m0_err_o / m1_err_o  out  1  transfer error (fault or timeout)
m0_dat_o / m1_dat_o  out  32  read data
s_cyc_o, s_stb_o, s_we_o  out  1 each  shared bus controls
s_adr_o  out  32  shared address; also drives decoder address
s_dat_o  out  32  shared write data
s_sel_o  out  4  shared byte selects
s_ack_i  in  1  slave acknowledge
s_dat_i  in  32  slave read data
s_fault_i  in  1  decoder fault, combinational from s_adr_o / s_cyc_o
grant_o  out  2  one-hot current owner; 00 when idle

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n_i is asynchronous, active-low.
- Reset values: state IDLE, grant_o=00, last_served=1 (master 0 wins the first tie), watchdog=0. All s_* outputs and all m*_ack/err are 0. m*_dat_o = 0.
- States: IDLE, OWN0, OWN1. The state register drives grant_o directly.
- IDLE:
  - Only one mX_cyc_i high: go to OWNX next edge.
  - Both high: grant the master not equal to last_served.
  - Neither high: stay in IDLE.
  - In IDLE, s_cyc_o = s_stb_o = 0.
- OWNX:
  - s_cyc_o, s_we_o, s_adr_o, s_dat_o, s_sel_o are combinational muxes of master X's inputs.
  - s_stb_o = mX_stb_i & ~s_fault_i.
  - Leave OWNX to IDLE on the edge where mX_cyc_i is sampled low; set last_served=X on that edge.
  - The other master's cyc is ignored while X owns the bus. Indefinite hold (bus lock) is legal.
- Handover latency: owner drops cyc at edge t → IDLE after t. The waiting master is granted at edge t+1, and its stb reaches s_stb_o in the cycle after t+1. Exactly one dead cycle.
- Ack and read data:
  - mX_ack_o = s_ack_i & mX_stb_i & ownX, combinational (zero added latency).
  - mX_dat_o = s_dat_i when ownX, else 0.
  - The non-owner's ack and err are always 0.
- Fault: mX_err_o is asserted combinationally when ownX & mX_stb_i & s_fault_i. The slave is not strobed. Err stays asserted for as long as the master keeps stb on a faulting address.
- Watchdog:
  - Increments each cycle with s_stb_o=1 and s_ack_i=0.
  - Clears on s_ack_i, on s_stb_o=0, and on leaving OWNX.
  - When the count equals TIMEOUT-1 and s_ack_i=0: mX_err_o is high for exactly that cycle, and the counter clears on the following edge.
  - Same cycle ack and terminal count: ack wins, err=0.
- ack and err are never asserted together. Fault takes precedence over the watchdog; the watchdog cannot run during a fault because s_stb_o=0.
- Mid-operation reset: on rst_n_i low, all outputs go to reset values immediately without waiting for a clock.
- A master raising stb without cyc gets no response.

Test Plan:
- Single master: m0 reads 0x0000_0010 with slave ack 2 cycles after stb → grant_o=01 one edge after cyc; m0_ack_o coincides with s_ack_i; m0_dat_o=s_dat_i (0xDEADBEEF). After m0 drops cyc, grant_o=00.
- Contention: m0 and m1 raise cyc on the same edge from reset → m0 granted first. m1 is granted one dead cycle after m0 releases. Raise both again → m0 granted after m1 releases (round-robin).
- Fault: m1 owns the bus and strobes 0x5000_0000 with s_fault_i=1 → m1_err_o=1 the same cycle, s_stb_o=0, m1_ack_o=0, watchdog stays at 0.
- Timeout: TIMEOUT=8, m0 strobes with ack never returned → m0_err_o pulses exactly one cycle at the 8th strobe cycle and repeats 8 cycles later if stb is held. Ack on the terminal cycle → ack only, no err.
- Lock/isolation: m0 holds cyc across 3 transfers while m1 requests → m1_ack_o and m1_err_o stay 0 and s_adr_o always tracks m0_adr_i.
- Async reset asserted mid-transfer (stb high, no ack) → s_cyc_o, s_stb_o, grant_o go to 0 before the next clock edge. After release, master 0 wins a tie.
